// File: rtl/sfft_frame_reader.sv
// sfft_frame_reader: bus initiator that drains one SFFT frame from the accelerator
// register window onto a valid/ready word stream. Optional feature macro: SFFT_READER_DUP_SKIP_EN.
module sfft_frame_reader #(
   parameter int N_WORDS    = 256,
   parameter int TIMER_BASE = 1024,
   parameter int VALID_ADDR = 1028,
   parameter int ADDR_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic [ADDR_W-1:0]          address,
   output logic                       chipselect,
   output logic                       write,
   output logic [7:0]                 writedata,
   input  logic [7:0]                 readdata,
   output logic [31:0]                bin_data,
   output logic [$clog2(N_WORDS)-1:0] bin_index,
   output logic                       bin_valid,
   input  logic                       bin_ready,
   output logic                       bin_last,
   output logic [31:0]                frame_time,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       frame_err
);

   localparam int IDX_W = $clog2(N_WORDS);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_WORDS - 1);
   localparam logic [ADDR_W-1:0] TIME_ADDR  = ADDR_W'(TIMER_BASE);
   localparam logic [ADDR_W-1:0] VALID_LOC  = ADDR_W'(VALID_ADDR);

   typedef enum logic [2:0] {
      S_IDLE, S_LOCK, S_SETTLE, S_CHKV, S_TIME, S_FETCH, S_PRESENT, S_UNLOCK
   } state_t;

   state_t            state_r;
   logic [1:0]        byte_r;
   logic [IDX_W-1:0]  word_r;
   logic [23:0]       shift_r;
   logic              err_r;
   logic [31:0]       assembled_s;
   logic              dup_s;

   // Bytes arrive low first, so the fourth byte completes the little-endian word.
   assign assembled_s = {readdata, shift_r};

`ifdef SFFT_READER_DUP_SKIP_EN
   logic [31:0] last_time_r;
   logic        have_last_r;

   assign dup_s = have_last_r && (assembled_s == last_time_r);

   // Remember the timestamp of the last frame whose final word was accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_time_r <= 32'h0000_0000;
         have_last_r <= 1'b0;
      end else if (state_r == S_PRESENT && bin_ready && word_r == LAST_IDX) begin
         last_time_r <= frame_time;
         have_last_r <= 1'b1;
      end
   end
`else
   assign dup_s = 1'b0;
`endif

   // Frame sequencer; every bus and stream output is a register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= S_IDLE;
         byte_r     <= 2'd0;
         word_r     <= '0;
         shift_r    <= 24'h00_0000;
         err_r      <= 1'b0;
         address    <= '0;
         chipselect <= 1'b0;
         write      <= 1'b0;
         writedata  <= 8'h00;
         bin_data   <= 32'h0000_0000;
         bin_index  <= '0;
         bin_valid  <= 1'b0;
         bin_last   <= 1'b0;
         frame_time <= 32'h0000_0000;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r    <= S_LOCK;
                  busy       <= 1'b1;
                  err_r      <= 1'b0;
                  chipselect <= 1'b1;
                  write      <= 1'b1;
                  writedata  <= 8'h01;
                  address    <= '0;
               end
            end
            S_LOCK: begin
               state_r    <= S_SETTLE;
               chipselect <= 1'b0;
               write      <= 1'b0;
               writedata  <= 8'h00;
            end
            S_SETTLE: begin
               state_r    <= S_CHKV;
               chipselect <= 1'b1;
               address    <= VALID_LOC;
            end
            S_CHKV: begin
               if (readdata[0]) begin
                  state_r <= S_TIME;
                  address <= TIME_ADDR;
                  byte_r  <= 2'd0;
               end else begin
                  err_r      <= 1'b1;
                  state_r    <= S_UNLOCK;
                  write      <= 1'b1;
                  writedata  <= 8'h00;
                  address    <= '0;
               end
            end
            S_TIME: begin
               if (byte_r == 2'd3) begin
                  frame_time <= assembled_s;
                  byte_r     <= 2'd0;
                  if (dup_s) begin
                     state_r   <= S_UNLOCK;
                     write     <= 1'b1;
                     writedata <= 8'h00;
                     address   <= '0;
                  end else begin
                     state_r <= S_FETCH;
                     word_r  <= '0;
                     address <= '0;
                  end
               end else begin
                  shift_r <= {readdata, shift_r[23:8]};
                  byte_r  <= byte_r + 2'd1;
                  address <= address + 1'b1;
               end
            end
            S_FETCH: begin
               if (byte_r == 2'd3) begin
                  state_r    <= S_PRESENT;
                  byte_r     <= 2'd0;
                  chipselect <= 1'b0;
                  bin_data   <= assembled_s;
                  bin_index  <= word_r;
                  bin_valid  <= 1'b1;
                  bin_last   <= (word_r == LAST_IDX);
               end else begin
                  shift_r <= {readdata, shift_r[23:8]};
                  byte_r  <= byte_r + 2'd1;
                  address <= address + 1'b1;
               end
            end
            S_PRESENT: begin
               if (bin_ready) begin
                  bin_valid  <= 1'b0;
                  bin_last   <= 1'b0;
                  chipselect <= 1'b1;
                  if (word_r == LAST_IDX) begin
                     state_r   <= S_UNLOCK;
                     write     <= 1'b1;
                     writedata <= 8'h00;
                     address   <= '0;
                  end else begin
                     // address still holds 4k+3, so +1 is the next word's byte 0
                     state_r <= S_FETCH;
                     word_r  <= word_r + 1'b1;
                     address <= address + 1'b1;
                  end
               end
            end
            S_UNLOCK: begin
               state_r    <= S_IDLE;
               busy       <= 1'b0;
               chipselect <= 1'b0;
               write      <= 1'b0;
               writedata  <= 8'h00;
               address    <= '0;
               frame_err  <= err_r;
               frame_done <= ~err_r;
            end
            default: begin
               state_r    <= S_IDLE;
               busy       <= 1'b0;
               chipselect <= 1'b0;
               write      <= 1'b0;
               bin_valid  <= 1'b0;
               bin_last   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sfft_frame_reader.md
Name: sfft_frame_reader

Overview:
- Hardware bus initiator that drains one SFFT frame from the accelerator's byte-wide register window.
- The window provides a control-flag write, a valid byte, a 4-byte timestamp and the bin words.
- Per frame it locks the output buffer, checks validity, reads the timestamp, then reads N_WORDS 32-bit words (bytes assembled little-endian) and releases the lock.
- Words leave on a valid/ready stream toward on-chip consumers such as a peak finder, replacing the software read loop.

Parameters:
N_WORDS, 256, number of 32-bit bin words per frame (bin byte addresses 0 .. 4*N_WORDS-1)
TIMER_BASE, 1024, byte address of timestamp byte 0; bytes 0..3 carry bits [7:0]..[31:24]
VALID_ADDR, 1028, byte address of the valid byte; bit 0 = 1 means the output is valid
ADDR_W, 16, bus address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to read one frame; ignored while busy=1
address  out  ADDR_W  bus byte address
chipselect  out  1  bus select
write  out  1  bus write strobe
writedata  out  8  bus write data (control flag)
readdata  in  8  bus read data, combinational from address
bin_data  out  32  assembled bin word
bin_index  out  $clog2(N_WORDS)  word index of bin_data
bin_valid  out  1  bin_data valid
bin_ready  in  1  consumer accepts bin_data
bin_last  out  1  high with bin_valid on word N_WORDS-1
frame_time  out  32  timestamp of the current/last frame
busy  out  1  high from the cycle after accepted start until the return to IDLE
frame_done  out  1  one-cycle pulse after a successful unlock
frame_err  out  1  one-cycle pulse when the valid byte reads 0

Behaviour:
- Reset (async assert, sync release): all outputs 0, address 0, state IDLE, frame_time 0.
- All bus outputs are registered.
- A read samples readdata at the rising edge that ends the cycle in which address is driven, with chipselect=1 and write=0: one byte per cycle, zero wait state.
- States:
  - IDLE: on start, go to LOCK.
  - LOCK: one cycle; chipselect=1, write=1, writedata=8'h01, address=0. Go to SETTLE.
  - SETTLE: one idle cycle (chipselect=0) so the flag register and timestamp snapshot freeze. Go to CHKV.
  - CHKV: read VALID_ADDR. If readdata[0]=0, go to UNLOCK with err flag set. Otherwise go to TIME.
  - TIME: read TIMER_BASE+0..3 over 4 cycles into frame_time[7:0]..[31:24]. frame_time updates only after all 4 bytes are captured. Go to FETCH, word 0.
  - FETCH: read bytes 4k+0..4k+3 into a shift register. Byte 4k+j lands in bits [8j+7:8j]. Go to PRESENT.
  - PRESENT: bin_valid=1, bin_index=k, bin_data stable, chipselect=0. On bin_valid&bin_ready: if k=N_WORDS-1 go to UNLOCK, else k<=k+1 and go to FETCH. Stays here indefinitely while bin_ready=0.
  - UNLOCK: one cycle; write 8'h00 to address 0. Pulse frame_err if err is set, else pulse frame_done. Go to IDLE.
- Latency: start to first bin_valid = 1+1+1+4+4 = 11 cycles. Best-case frame = 11 + 5*(N_WORDS-1) + 1 + 1 cycles.
- bin_last = bin_valid & (k = N_WORDS-1).
- start arriving in the UNLOCK cycle is ignored (busy is still high).
- Reset mid-frame: returns to IDLE with bus outputs 0. The accelerator flag may stay at 1; the next LOCK rewrites it and UNLOCK clears it, so no recovery write is needed.
- Bins are never streamed for an invalid frame. frame_time keeps its previous value on error.

Optional Feature:
- Macro: SFFT_READER_DUP_SKIP_EN.
- Defined: after TIME, if the new timestamp equals the timestamp of the last successfully delivered frame (and at least one such frame exists since reset), skip FETCH/PRESENT. Go straight to UNLOCK and pulse frame_done with no bin_valid. Adds a 32-bit last-delivered register and a first-frame flag.
- Undefined: every valid frame is streamed.

Test Plan:
- Reset with start held high → all outputs 0. After release, exactly one frame runs per start pulse; a start asserted during busy is dropped.
- Model valid=1, timestamp 0x0000_0042, byte a holds a[7:0] → frame_time=0x42. Word k = {4k+3,4k+2,4k+1,4k} (low byte of each address). Word 0 = 0x03020100. First bin_valid 11 cycles after start. frame_done 1 cycle after the last handshake. Bus write sequence is exactly 0x01 then 0x00.
- Valid byte 0x00 → no bin_valid, frame_err pulses, exactly two writes (0x01, 0x00), frame_time unchanged.
- bin_ready low for 7 cycles on word 5 → bin_data/bin_index held, no bus reads. Resume yields word 6 with no words lost.
- Reset asserted during FETCH of word 3 → immediate all-zero outputs. The next start produces a complete frame beginning at index 0.
- With SFFT_READER_DUP_SKIP_EN: two frames both at timestamp 0x10 → second produces no bins and pulses frame_done. Third frame at 0x11 streams all N_WORDS words.
